ofdm_tx_scheduler: RTL and testbench

OFDM_TX_SCHEDULER -- requirements
Module: ofdm_tx_scheduler

---
 rtl/ofdm_tx_scheduler_pkg.sv | 26 ++
 rtl/ofdm_scrambler.sv | 35 +++
 rtl/ofdm_tx_scheduler.sv | 167 ++++++++++++++++
 tb/tb_ofdm_tx_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_tx_scheduler_pkg.sv
// Shared definitions for the OFDM transmit scheduler: FSM encoding, symbol
// geometry helper and the scrambler LFSR constants (x^7 + x^4 + 1).
package ofdm_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_PAD      = 3'd3,
    S_DRAIN    = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  localparam logic [6:0] LFSR_SEED = 7'h7F;
  // Taps on stages 7 and 4; the XOR of the tapped bits shifts in at bit 0.
  localparam logic [6:0] LFSR_TAPS = 7'b100_1000;

  function automatic int bytes_per_sym(input int n, input int log2m, input int b);
    return (n * log2m) / b;
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ofdm_scrambler.sv
// Byte-wide additive scrambler: emits B keystream bits from the current LFSR
// state; load reseeds, advance steps the register by B positions.
module ofdm_scrambler
  import ofdm_tx_scheduler_pkg::*;
#(
  parameter int B = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic         advance,
  output logic [B-1:0] key
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_nxt;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path infers a latch.
    lfsr_nxt = lfsr_q;
    key      = '0;
    for (int i = 0; i < B; i++) begin
      lfsr_nxt = lfsr_step(lfsr_nxt);
      key[i]   = lfsr_nxt[0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: flops use <= so every register samples pre-edge values.
    if (!aresetn)     lfsr_q <= LFSR_SEED;
    else if (load)    lfsr_q <= LFSR_SEED;
    else if (advance) lfsr_q <= lfsr_nxt;
  end

endmodule

// File: rtl/ofdm_tx_scheduler.sv
// Frame scheduler feeding a QAM mapper: preamble, payload, pad, drain, gap.
// Define SCRAMBLER_EN to XOR payload bytes with the ofdm_scrambler keystream.
module ofdm_tx_scheduler
  import ofdm_tx_scheduler_pkg::*;
#(
  parameter int             B             = 8,
  parameter int             N             = 16,
  parameter int             LOG2M         = 6,
  parameter int             PREAMBLE_SYMS = 1,
  parameter logic [B-1:0]   PREAMBLE_BYTE = 8'hA5,
  parameter logic [B-1:0]   PAD_BYTE      = 8'h00,
  parameter int             GAP_CYCLES    = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         enable,
  input  logic [7:0]   cfg_carrier_control,
  input  logic [7:0]   cfg_num_syms,
  input  logic [B-1:0] s_tdata,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  output logic         s_tready,
  output logic [B-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [7:0]   carrier_control,
  input  logic         sym_done,
  output logic         frame_busy,
  output logic         frame_done,
  output logic [7:0]   sym_count
);

  localparam int BPS   = bytes_per_sym(N, LOG2M, B);
  localparam int IDX_W = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] gen_idx, tx_idx;
  logic [7:0]       gen_sym, frame_limit, in_flight;
  logic [15:0]      gap_cnt;
  logic [B-1:0]     load_data, payload_key;
  logic             load, load_ok, sent, sym_end_tx, sym_done_ok;
  logic             frame_start, drain_ok, gap_last;

  assign load_ok     = !m_tvalid || m_tready;
  assign sent        = m_tvalid && m_tready;
  assign sym_end_tx  = sent && (tx_idx == LAST_IDX);
  assign sym_done_ok = sym_done && (state != S_IDLE);
  assign frame_start = (state == S_IDLE) && enable;
  assign gap_last    = (int'(gap_cnt) + 1) >= GAP_CYCLES;
  assign s_tready    = (state == S_PAYLOAD) && load_ok;
  assign frame_busy  = (state != S_IDLE);

`ifdef SCRAMBLER_EN
  logic payload_adv;
  // The keystream steps when a payload byte enters the output register; every
  // such byte is eventually sent, so the sequence matches the sent bytes.
  assign payload_adv = (state == S_PAYLOAD) && load;

  ofdm_scrambler #(.B(B)) u_scrambler (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (frame_start),
    .advance (payload_adv),
    .key     (payload_key)
  );
`else
  assign payload_key = '0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = '0;
    drain_ok  = 1'b0;
    unique case (state)
      S_IDLE: if (enable) state_nxt = S_PREAMBLE;
      S_PREAMBLE: begin
        load      = load_ok;
        load_data = PREAMBLE_BYTE;
        if (load_ok && gen_idx == LAST_IDX && gen_sym == 8'(PREAMBLE_SYMS - 1))
          state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (load_ok && s_tvalid) begin
          load      = 1'b1;
          load_data = s_tdata ^ payload_key;
          // A symbol-aligned tlast or the symbol limit ends without padding.
          if (gen_idx == LAST_IDX) begin
            if (s_tlast || (gen_sym + 8'd1) == frame_limit) state_nxt = S_DRAIN;
          end else if (s_tlast) begin
            state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        load      = load_ok;
        load_data = PAD_BYTE;
        if (load_ok && gen_idx == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!m_tvalid && in_flight == 8'd0) begin
          drain_ok  = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: if (gap_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output register: a new byte may enter only when the slot is empty or draining.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= load_data;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gen_idx         <= '0;
      gen_sym         <= '0;
      tx_idx          <= '0;
      sym_count       <= '0;
      in_flight       <= '0;
      frame_limit     <= 8'd1;
      carrier_control <= 8'hFF;
      frame_done      <= 1'b0;
      gap_cnt         <= '0;
    end else begin
      frame_done <= drain_ok;
      gap_cnt    <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (frame_start) begin
        gen_idx         <= '0;
        gen_sym         <= '0;
        tx_idx          <= '0;
        sym_count       <= '0;
        in_flight       <= '0;
        carrier_control <= cfg_carrier_control;
        frame_limit     <= (cfg_num_syms == 8'd0) ? 8'd1 : cfg_num_syms;
      end else begin
        // gen_* track bytes loaded (sequencing); tx_* track bytes handed off.
        if (load) begin
          gen_idx <= (gen_idx == LAST_IDX) ? '0 : gen_idx + 1'b1;
          if (gen_idx == LAST_IDX)
            gen_sym <= (state == S_PREAMBLE && state_nxt == S_PAYLOAD) ? 8'd0 : gen_sym + 8'd1;
        end
        if (sent) tx_idx <= (tx_idx == LAST_IDX) ? '0 : tx_idx + 1'b1;
        if (sym_end_tx) sym_count <= sym_count + 8'd1;
        if (sym_end_tx && !sym_done_ok)      in_flight <= in_flight + 8'd1;
        else if (!sym_end_tx && sym_done_ok) in_flight <= in_flight - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_tx_scheduler.sv
// Directed bench for ofdm_tx_scheduler; acts as byte source and as the mapper
// (counting received bytes and returning one sym_done per 12-byte symbol).
module tb_ofdm_tx_scheduler;

  localparam int BPS = 12;
`ifdef SCRAMBLER_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] cfg_carrier_control = 8'h00;
  logic [7:0] cfg_num_syms = 8'h00;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic [7:0] carrier_control;
  logic       sym_done = 1'b0;
  logic       frame_busy;
  logic       frame_done;
  logic [7:0] sym_count;

  always #5 aclk = ~aclk;

  ofdm_tx_scheduler dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .enable              (enable),
    .cfg_carrier_control (cfg_carrier_control),
    .cfg_num_syms        (cfg_num_syms),
    .s_tdata             (s_tdata),
    .s_tvalid            (s_tvalid),
    .s_tlast             (s_tlast),
    .s_tready            (s_tready),
    .m_tdata             (m_tdata),
    .m_tvalid            (m_tvalid),
    .m_tready            (m_tready),
    .carrier_control     (carrier_control),
    .sym_done            (sym_done),
    .frame_busy          (frame_busy),
    .frame_done          (frame_done),
    .sym_count           (sym_count)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] src_data[$];
  logic       src_last[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  int done_pulses, frames_done, sym_at_done, pulses_at_done;

  // Keystream byte n of x^7+x^4+1 from seed 7F, bit 0 produced first.
  function automatic logic [7:0] key_byte(input int n);
    logic [6:0] s = 7'h7F;
    logic [7:0] k = 8'h00;
    logic fb;
    for (int j = 0; j <= n; j++)
      for (int i = 0; i < 8; i++) begin
        fb = s[6] ^ s[3];
        k[i] = fb;
        s = {s[5:0], fb};
      end
    return k;
  endfunction

  function automatic logic [7:0] pay(input logic [7:0] d, input int idx);
    return d ^ (SCR ? key_byte(idx) : 8'h00);
  endfunction

  task automatic load_src(input logic [7:0] first, input int n, input int step, input int last_at);
    src_data.delete();
    src_last.delete();
    for (int i = 0; i < n; i++) begin
      src_data.push_back(first + 8'(i * step));
      src_last.push_back(i == last_at);
    end
  endtask

  task automatic exp_frame(input logic [7:0] first, input int n, input int step, input int pad);
    exp_q.delete();
    repeat (BPS) exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) exp_q.push_back(pay(first + 8'(i * step), i));
    repeat (pad) exp_q.push_back(8'h00);
  endtask

  // Drives one frame cycle by cycle from the negedge; returns after the frame
  // completes (busy low after frame_done) or after stop_after output bytes.
  task automatic run_frame(input int rdy_mode, input int vld_mode, input int sd_delay,
                           input int stop_after, input int chg_cyc);
    int rx = 0;
    int due[$];
    logic [7:0] held = 8'h00;
    logic held_v = 1'b0;
    logic fin = 1'b0;
    out_q.delete();
    done_pulses = 0; frames_done = 0; sym_at_done = -1; pulses_at_done = -1;
    enable = 1'b1;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge aclk);
      enable = 1'b0;
      if (cyc == chg_cyc) begin
        cfg_carrier_control = 8'h81;
        cfg_num_syms = 8'd5;
      end
      m_tready = (rdy_mode == 0) ? 1'b1 : 1'(cyc % 2);
      s_tvalid = (src_data.size() > 0) && (vld_mode == 0 || cyc % 3 != 0);
      s_tdata  = (src_data.size() > 0) ? src_data[0] : 8'h00;
      s_tlast  = (src_last.size() > 0) ? src_last[0] : 1'b0;
      sym_done = (due.size() > 0) && (due[0] <= cyc);
      if (sym_done) void'(due.pop_front());
      #1;
      if (frame_done) begin
        frames_done++;
        sym_at_done = sym_count;
        pulses_at_done = done_pulses;
      end
      if (held_v && m_tvalid) begin
        checks++;
        if (m_tdata !== held) begin
          failures++;
          $display("FAIL stall_hold: m_tdata=%02h expected %02h", m_tdata, held);
        end
      end
      held_v = m_tvalid && !m_tready;
      held = m_tdata;
      if (m_tvalid && m_tready) begin
        out_q.push_back(m_tdata);
        rx++;
        if (rx == BPS) begin
          rx = 0;
          due.push_back(cyc + 1 + sd_delay);
        end
      end
      if (s_tvalid && s_tready) begin
        void'(src_data.pop_front());
        void'(src_last.pop_front());
      end
      if (sym_done) done_pulses++;
      if (stop_after > 0 && out_q.size() >= stop_after) fin = 1'b1;
      if (frames_done > 0 && !frame_busy) fin = 1'b1;
    end
    sym_done = 1'b0;
    s_tvalid = 1'b0;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL frame_timeout: got %0d bytes, frame_done count %0d, expected completion", out_q.size(), frames_done);
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    checks++;
    if ({m_tvalid, s_tready, frame_busy, frame_done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {m_tvalid, s_tready, frame_busy, frame_done});
    end
    checks++;
    if (m_tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata: got %02h expected 00", m_tdata); end
    checks++;
    if (carrier_control !== 8'hFF) begin failures++; $display("FAIL reset_cc: got %02h expected ff", carrier_control); end
    checks++;
    if (sym_count !== 8'h00) begin failures++; $display("FAIL reset_symcnt: got %0d expected 0", sym_count); end
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    #1;
    checks++;
    if (frame_busy !== 1'b0) begin failures++; $display("FAIL idle_no_enable: frame_busy=%b expected 0", frame_busy); end
  endtask

  task automatic test_basic_and_config;
    int bad;
    cfg_carrier_control = 8'h3C;
    cfg_num_syms = 8'd2;
    load_src(8'h00, 26, 1, -1);
    exp_frame(8'h00, 24, 1, 0);
    run_frame(0, 0, 20, 0, 30);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
    if (bad < 0 && out_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL basic_stream: first diff at byte %0d, got %0d bytes expected %0d", bad, out_q.size(), exp_q.size());
    end
    checks++;
    if (sym_at_done !== 3) begin failures++; $display("FAIL basic_symcnt: got %0d expected 3", sym_at_done); end
    checks++;
    if (pulses_at_done !== 3) begin failures++; $display("FAIL basic_done_wait: sym_done pulses at frame_done %0d expected 3", pulses_at_done); end
    checks++;
    if (carrier_control !== 8'h3C) begin failures++; $display("FAIL cc_midframe: got %02h expected 3c", carrier_control); end
    checks++;
    if (src_data.size() !== 2) begin failures++; $display("FAIL limit_leftover: got %0d source bytes left expected 2", src_data.size()); end

    // Next frame picks up 0x81 / 5 symbols; tlast on the final symbol byte.
    load_src(8'h40, 12, 1, 11);
    exp_frame(8'h40, 12, 1, 0);
    run_frame(0, 0, 0, 0, -1);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
    if (bad < 0 && out_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL tlast_last_stream: first diff at byte %0d, got %0d bytes expected %0d", bad, out_q.size(), exp_q.size());
    end
    checks++;
    if (carrier_control !== 8'h81) begin failures++; $display("FAIL cc_next_frame: got %02h expected 81", carrier_control); end
    checks++;
    if (sym_at_done !== 2) begin failures++; $display("FAIL tlast_last_symcnt: got %0d expected 2", sym_at_done); end
  endtask

  task automatic test_tlast_pad;
    int bad;
    cfg_num_syms = 8'd4;
    load_src(8'h30, 5, 1, 4);
    exp_frame(8'h30, 5, 1, 7);
    run_frame(0, 0, 3, 0, -1);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
    if (bad < 0 && out_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL pad_stream: first diff at byte %0d, got %0d bytes expected %0d", bad, out_q.size(), exp_q.size());
    end
    checks++;
    if (sym_at_done !== 2) begin failures++; $display("FAIL pad_symcnt: got %0d expected 2", sym_at_done); end
  endtask

  task automatic test_backpressure;
    int bad;
    // Stray sym_done pulses while idle must not disturb the next frame.
    repeat (3) begin
      @(negedge aclk);
      sym_done = 1'b1;
    end
    @(negedge aclk);
    sym_done = 1'b0;
    cfg_num_syms = 8'd2;
    load_src(8'h03, 24, 7, -1);
    exp_frame(8'h03, 24, 7, 0);
    run_frame(1, 0, 0, 0, -1);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
    if (bad < 0 && out_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL bp_stream: first diff at byte %0d, got %0d bytes expected %0d", bad, out_q.size(), exp_q.size());
    end
    checks++;
    if (sym_at_done !== 3) begin failures++; $display("FAIL bp_symcnt: got %0d expected 3", sym_at_done); end
    checks++;
    if (pulses_at_done !== 3) begin failures++; $display("FAIL bp_done_wait: sym_done pulses at frame_done %0d expected 3", pulses_at_done); end
  endtask

  task automatic test_source_stall;
    int bad;
    cfg_num_syms = 8'd0;
    load_src(8'h90, 13, 1, -1);
    exp_frame(8'h90, 12, 1, 0);
    run_frame(0, 1, 5, 0, -1);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
    if (bad < 0 && out_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL stall_stream: first diff at byte %0d, got %0d bytes expected %0d", bad, out_q.size(), exp_q.size());
    end
    checks++;
    if (src_data.size() !== 1) begin failures++; $display("FAIL zero_limit_leftover: got %0d left expected 1", src_data.size()); end
    checks++;
    if (sym_at_done !== 2) begin failures++; $display("FAIL stall_symcnt: got %0d expected 2", sym_at_done); end
  endtask

  task automatic test_reset_mid;
    int bad;
    cfg_carrier_control = 8'h3C;
    cfg_num_syms = 8'd2;
    load_src(8'h20, 24, 1, -1);
    run_frame(0, 0, 0, 16, -1);
    checks++;
    if (frame_busy !== 1'b1) begin failures++; $display("FAIL mid_busy: frame_busy=%b expected 1", frame_busy); end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, s_tready, frame_busy, frame_done} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_flags: got %b expected 0000", {m_tvalid, s_tready, frame_busy, frame_done});
    end
    checks++;
    if ({m_tdata, carrier_control, sym_count} !== {8'h00, 8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL mid_reset_vals: tdata=%02h cc=%02h symcnt=%0d expected 00 ff 0", m_tdata, carrier_control, sym_count);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    cfg_num_syms = 8'd1;
    load_src(8'h50, 12, 1, -1);
    exp_frame(8'h50, 12, 1, 0);
    run_frame(0, 0, 0, 0, -1);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
    if (bad < 0 && out_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL restart_stream: first diff at byte %0d, got %0d bytes expected %0d", bad, out_q.size(), exp_q.size());
    end
  endtask

  task automatic test_scrambler;
    int bad;
    cfg_num_syms = 8'd1;
    for (int f = 0; f < 2; f++) begin
      load_src(8'h00, 12, 0, -1);
      exp_frame(8'h00, 12, 0, 0);
      run_frame(0, 0, 0, 0, -1);
      bad = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && (i >= out_q.size() || out_q[i] !== exp_q[i])) bad = i;
      if (bad < 0 && out_q.size() != exp_q.size()) bad = exp_q.size();
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL scr_stream frame %0d: first diff at byte %0d, got %0d bytes expected %0d", f, bad, out_q.size(), exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_and_config();
    test_tlast_pad();
    test_backpressure();
    test_source_stall();
    test_reset_mid();
    test_scrambler();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
